fstage_fetch: RTL

Instruction-fetch stage of the multi-cycle NPC core. Holds the architectural PC and issues one read per instruction on an AXI4-Lite-style read channel (AR/R). It presents the fetched instruction, its PC and its sequential next PC (pc+4) to the decode-stage pipeline register through a valid/ready handshake. It accepts PC redirects from execute/writeback and discards any in-flight fetch that a redirect makes stale.

---
 rtl/fstage_fetch_pkg.sv | 25 ++
 rtl/fstage_fetch.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/fstage_fetch_pkg.sv
// Shared definitions for the fetch stage: state encoding, bus response
// codes, the default reset PC and small address helpers.
package fstage_fetch_pkg;

  typedef enum logic [1:0] {
    S_AR  = 2'd0,
    S_R   = 2'd1,
    S_OUT = 2'd2
  } state_e;

  localparam logic [1:0]  RESP_OKAY        = 2'b00;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
  localparam logic [31:0] INST_BYTES       = 32'd4;

  // Word-aligned bus address for a PC.
  function automatic logic [31:0] word_addr(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

  // True when the PC is not on a 4-byte boundary.
  function automatic logic is_misaligned(input logic [31:0] pc);
    return (pc[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/fstage_fetch.sv
// Instruction-fetch stage: holds the PC, issues one AR/R read per
// instruction and hands instF/pcF/snpcF to decode via m_valid/m_ready.
// Redirects replace the PC; a fetch already on the bus is completed and
// its data dropped (kill flag).
// Optional feature: define MISALIGN_CHECK_EN to turn a misaligned PC into
// an immediate fetch_err delivery without any bus request.
module fstage_fetch
  import fstage_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] instF,
  output logic [31:0] pcF,
  output logic [31:0] snpcF,
  output logic        fetch_err,
  output logic        m_valid,
  input  logic        m_ready
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        kill_q, kill_d;
  logic [31:0] araddr_q, araddr_d;
  logic        arvalid_q, arvalid_d;
  logic        rready_q, rready_d;
  logic        mvalid_q, mvalid_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] pcf_q, pcf_d;
  logic [31:0] snpc_q, snpc_d;
  logic        err_q, err_d;
  logic        ar_fire_s;
  logic        r_fire_s;

  assign ar_fire_s = arvalid_q && arready;
  assign r_fire_s  = rready_q && rvalid;

  // FSM next state, PC/kill bookkeeping and capture of the decode outputs
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    kill_d  = kill_q;
    inst_d  = inst_q;
    pcf_d   = pcf_q;
    snpc_d  = snpc_q;
    err_d   = err_q;
    case (state_q)
      S_AR: begin
        if (redirect_valid) begin
          // Only an address already on the bus becomes stale.
          pc_d   = redirect_pc;
          kill_d = arvalid_q;
        end else begin
          pc_d = pc_q;
        end
        if (ar_fire_s) begin
          state_d = S_R;
        end
`ifdef MISALIGN_CHECK_EN
        else if (!arvalid_q && !redirect_valid && is_misaligned(pc_q)) begin
          state_d = S_OUT;
          inst_d  = 32'h0000_0000;
          pcf_d   = pc_q;
          snpc_d  = pc_q + INST_BYTES;
          err_d   = 1'b1;
        end
`endif
        else begin
          state_d = S_AR;
        end
      end
      S_R: begin
        if (r_fire_s) begin
          kill_d = 1'b0;
          if (kill_q || redirect_valid) begin
            // Stale data: refetch from the (possibly new) PC.
            state_d = S_AR;
            if (redirect_valid) begin
              pc_d = redirect_pc;
            end else begin
              pc_d = pc_q;
            end
          end else begin
            state_d = S_OUT;
            inst_d  = rdata;
            pcf_d   = pc_q;
            snpc_d  = pc_q + INST_BYTES;
            err_d   = (rresp != RESP_OKAY);
          end
        end else if (redirect_valid) begin
          pc_d   = redirect_pc;
          kill_d = 1'b1;
        end else begin
          state_d = S_R;
        end
      end
      S_OUT: begin
        // Redirect wins over the sequential PC even on a handshake cycle.
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = S_AR;
        end else if (m_ready) begin
          pc_d    = pc_q + INST_BYTES;
          state_d = S_AR;
        end else begin
          state_d = S_OUT;
        end
      end
      default: begin
        state_d = S_AR;
        kill_d  = 1'b0;
      end
    endcase
  end

  // Handshake outputs derived from the next state so they leave flops directly
  always_comb begin
    rready_d = (state_d == S_R);
    mvalid_d = (state_d == S_OUT);
`ifdef MISALIGN_CHECK_EN
    arvalid_d = (state_d == S_AR) && (kill_d || !is_misaligned(pc_d));
`else
    arvalid_d = (state_d == S_AR);
`endif
    if ((state_q == S_AR) && arvalid_q) begin
      araddr_d = araddr_q;
    end else begin
      araddr_d = word_addr(pc_d);
    end
  end

  // State, PC and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_AR;
      pc_q      <= RESET_PC;
      kill_q    <= 1'b0;
      araddr_q  <= word_addr(RESET_PC);
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      mvalid_q  <= 1'b0;
      inst_q    <= 32'h0000_0000;
      pcf_q     <= RESET_PC;
      snpc_q    <= RESET_PC + INST_BYTES;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      kill_q    <= kill_d;
      araddr_q  <= araddr_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      mvalid_q  <= mvalid_d;
      inst_q    <= inst_d;
      pcf_q     <= pcf_d;
      snpc_q    <= snpc_d;
      err_q     <= err_d;
    end
  end

  assign araddr    = araddr_q;
  assign arvalid   = arvalid_q;
  assign rready    = rready_q;
  assign m_valid   = mvalid_q;
  assign instF     = inst_q;
  assign pcF       = pcf_q;
  assign snpcF     = snpc_q;
  assign fetch_err = err_q;

endmodule
